// File: rtl/puf_request_scheduler.sv
//------------------------------------------------------------------------------
// puf_request_scheduler
//
// Shares one RO-PUF core among NREQ requesters. A round-robin arbiter picks a
// requester and drives the PUF controller's start/done handshake. The captured
// RESP_W-bit response goes back to the granted requester as WORD_W-bit beats
// over a valid/ready channel. A watchdog aborts a hung measurement and returns
// a single error beat in place of the response.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   req       in   [NREQ]    per-requester request level
//   grant     out  [NREQ]    one-hot grant, held for the whole transaction
//   busy      out            high whenever the scheduler is not idle
//   puf_start out            PUF controller start
//   puf_done  in             one-cycle done pulse from the PUF controller
//   puf_resp  in   [RESP_W]  PUF response, valid in the puf_done cycle
//   rd_data   out  [WORD_W]  response beat
//   rd_valid  out            beat valid
//   rd_ready  in             granted requester accepts the beat
//   rd_last   out            final beat of the transaction
//   rd_err    out            beat is a timeout error beat
//------------------------------------------------------------------------------
module puf_request_scheduler #(
   parameter int NREQ    = 4,
   parameter int RESP_W  = 256,
   parameter int WORD_W  = 32,
   parameter int TO_W    = 17,
   parameter int TIMEOUT = 131071
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              puf_start,
   input  logic              puf_done,
   input  logic [RESP_W-1:0] puf_resp,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last,
   output logic              rd_err
);

   localparam int BEATS = RESP_W / WORD_W;
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
   localparam logic [TO_W-1:0]  TO_VAL   = TO_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_STREAM,
      S_ERR
   } state_t;

   state_t              state;
   state_t              next_state;

   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    gnt_idx;
   logic [RESP_W-1:0]   resp_buf;
   logic [IDX_W-1:0]    idx;
   logic [TO_W-1:0]     cnt;

   logic                sel_found;
   logic [PTR_W-1:0]    sel_idx;

   logic                wd_expired;
   logic                last_beat;

   assign wd_expired = (cnt == TO_VAL);
   assign last_beat  = (idx == LAST_IDX);

   // Round-robin pick: scan upward from ptr+1 with wrap, so the most recently
   // served requester is considered last.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = ptr;
      for (int o = 1; o <= NREQ; o++) begin
         int cand;
         cand = int'(ptr) + o;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = PTR_W'(cand);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. In WAIT a done pulse takes priority over the watchdog,
   // so a response arriving in the very cycle the count expires is kept.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (sel_found) begin
               next_state = S_START;
            end
         end
         S_START: begin
            next_state = S_WAIT;
         end
         S_WAIT: begin
            if (puf_done) begin
               next_state = S_STREAM;
            end else if (wd_expired) begin
               next_state = S_ERR;
            end
         end
         S_STREAM: begin
            if (rd_ready && last_beat) begin
               next_state = S_IDLE;
            end
         end
         S_ERR: begin
            if (rd_ready) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Datapath: grant/pointer bookkeeping, response capture, beat index and
   // watchdog. The watchdog stops counting once it reaches TIMEOUT, which is
   // exactly the cycle WAIT leaves for ERR, so it never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= PTR_W'(NREQ - 1);
         gnt_idx  <= '0;
         grant    <= '0;
         resp_buf <= '0;
         idx      <= '0;
         cnt      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  grant   <= NREQ'(1) << sel_idx;
                  gnt_idx <= sel_idx;
               end
            end
            S_START: begin
               cnt <= '0;
            end
            S_WAIT: begin
               if (puf_done) begin
                  resp_buf <= puf_resp;
                  idx      <= '0;
               end else if (!wd_expired) begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STREAM: begin
               if (rd_ready) begin
                  if (last_beat) begin
                     ptr   <= gnt_idx;
                     grant <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_ERR: begin
               if (rd_ready) begin
                  ptr   <= gnt_idx;
                  grant <= '0;
               end
            end
            default: begin
               grant <= '0;
            end
         endcase
      end
   end

   // Outputs decoded from state. Because beat data and last come straight
   // from the held buffer and index, they stay put while the reader stalls.
   always_comb begin
      busy      = (state != S_IDLE);
      puf_start = 1'b0;
      rd_valid  = 1'b0;
      rd_last   = 1'b0;
      rd_err    = 1'b0;
      rd_data   = '0;
      case (state)
         S_START, S_WAIT: begin
            puf_start = 1'b1;
         end
         S_STREAM: begin
            rd_valid = 1'b1;
            rd_last  = last_beat;
            rd_data  = resp_buf[idx*WORD_W +: WORD_W];
         end
         S_ERR: begin
            rd_valid = 1'b1;
            rd_last  = 1'b1;
            rd_err   = 1'b1;
         end
         default: begin
            puf_start = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_puf_request_scheduler.sv
//------------------------------------------------------------------------------
// tb_puf_request_scheduler
//
// Self-checking bench for puf_request_scheduler. A small reference model keeps
// the round-robin pointer and predicts grants, start-pulse length, beat
// contents and error beats for each transaction.
//------------------------------------------------------------------------------
module tb_puf_request_scheduler;

   localparam int NREQ   = 4;
   localparam int RESP_W = 256;
   localparam int WORD_W = 32;
   localparam int TO_W   = 17;
   localparam int TMO    = 320;
   localparam int BEATS  = RESP_W / WORD_W;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   grant;
   logic              busy;
   logic              puf_start;
   logic              puf_done;
   logic [RESP_W-1:0] puf_resp;
   logic [WORD_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic              rd_last;
   logic              rd_err;

   int nChecks;
   int nFails;
   int modelPtr;

   puf_request_scheduler #(
      .NREQ(NREQ), .RESP_W(RESP_W), .WORD_W(WORD_W), .TO_W(TO_W), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .grant(grant), .busy(busy),
      .puf_start(puf_start), .puf_done(puf_done), .puf_resp(puf_resp),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_last(rd_last), .rd_err(rd_err)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point, counted and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [RESP_W-1:0] obs,
                              input logic [RESP_W-1:0] exp);
      nChecks++;
      assert (obs === exp)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arbiter: first requester above the last-served one, wrapping.
   function automatic int pickIdx(input logic [NREQ-1:0] r, input int p);
      for (int o = 1; o <= NREQ; o++) begin
         int i;
         i = (p + o) % NREQ;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic applyReset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      modelPtr = NREQ - 1;
      tick();
   endtask

   // One full transaction.
   //   doneAt  : WAIT cycle index carrying puf_done, or -1 for a timeout
   //   rdyMode : 0 always ready, 1 pattern 1,0,0,..., 2 random
   //   rstBeat : beat index at which reset is pulsed mid-stream, or -1
   task automatic applyStimulus(input logic [NREQ-1:0] reqv, input int doneAt,
                                input logic [RESP_W-1:0] resp, input int rdyMode,
                                input int rstBeat);
      int                expIdx;
      int                startCycles;
      int                k;
      int                beat;
      int                cyc;
      int                stalled;
      logic              rdy;
      logic [WORD_W:0]   prevBeat;
      logic [WORD_W-1:0] wordQ[$];
      logic [RESP_W-1:0] tmp;

      checkOutput("idle_busy", {255'd0, busy}, '0);
      req    = reqv;
      expIdx = pickIdx(reqv, modelPtr);
      tick();
      checkOutput("grant", {252'd0, grant}, RESP_W'(1) << expIdx);
      checkOutput("busy_after_grant", {255'd0, busy}, 1);
      // Dropping requests after the grant must not abort the transaction.
      req = NREQ'($urandom);

      startCycles = 0;
      k = 0;
      while (puf_start === 1'b1 && k < TMO + 10) begin
         startCycles++;
         if (doneAt >= 0 && k == doneAt + 1) begin
            puf_done = 1'b1;
            puf_resp = resp;
         end
         tick();
         puf_done = 1'b0;
         puf_resp = {8{$urandom}};
         k++;
      end
      checkOutput("start_cycles", RESP_W'(startCycles),
                  RESP_W'((doneAt >= 0) ? doneAt + 2 : TMO + 2));
      checkOutput("first_valid", {255'd0, rd_valid}, 1);
      checkOutput("err_flag", {255'd0, rd_err}, (doneAt < 0) ? 1 : 0);

      if (doneAt < 0) begin
         int stallN;
         stallN = $urandom_range(0, 2);
         for (int s = 0; s <= stallN; s++) begin
            checkOutput("err_beat", {252'd0, rd_valid, rd_err, rd_last, puf_start}, 4'b1110);
            checkOutput("err_data", {224'd0, rd_data}, '0);
            rd_ready = (s == stallN);
            tick();
         end
      end else begin
         tmp = resp;
         for (int b = 0; b < BEATS; b++) begin
            wordQ.push_back(tmp[WORD_W-1:0]);
            tmp = tmp >> WORD_W;
         end
         beat = 0;
         cyc = 0;
         stalled = 0;
         prevBeat = '0;
         while (beat < BEATS && cyc < BEATS * 8 + 20) begin
            checkOutput("stream_valid", {253'd0, rd_valid, rd_err, puf_start}, 3'b100);
            if (stalled != 0) begin
               checkOutput("stall_stable", {223'd0, rd_last, rd_data}, {223'd0, prevBeat});
            end
            if (beat == rstBeat) begin
               rd_ready = 1'b0;
               #2 rst = 1'b1;
               #1;
               checkOutput("async_reset",
                           {216'd0, grant, busy, puf_start, rd_valid, rd_last, rd_err, rd_data}, '0);
               @(posedge clk);
               #1;
               rst = 1'b0;
               modelPtr = NREQ - 1;
               req = '0;
               tick();
               return;
            end
            case (rdyMode)
               0:       rdy = 1'b1;
               1:       rdy = ((cyc % 3) == 0);
               default: rdy = 1'($urandom);
            endcase
            rd_ready = rdy;
            if (rdy) begin
               checkOutput("beat_data", {224'd0, rd_data}, {224'd0, wordQ.pop_front()});
               checkOutput("beat_last", {255'd0, rd_last}, (beat == BEATS - 1) ? 1 : 0);
               beat++;
               stalled = 0;
            end else begin
               stalled = 1;
            end
            prevBeat = {rd_last, rd_data};
            // Stray done pulses with junk data must not disturb the buffer.
            if (($urandom % 4) == 0) begin
               puf_done = 1'b1;
               puf_resp = {8{$urandom}};
            end
            tick();
            puf_done = 1'b0;
            cyc++;
         end
         checkOutput("beats_accepted", RESP_W'(beat), RESP_W'(BEATS));
      end
      rd_ready = 1'b0;
      req = '0;
      checkOutput("back_to_idle", {250'd0, grant, busy, rd_valid}, '0);
      modelPtr = expIdx;
   endtask

   initial begin
      logic [RESP_W-1:0] pat;
      nChecks  = 0;
      nFails   = 0;
      modelPtr = NREQ - 1;
      rst      = 1'b1;
      req      = '0;
      puf_done = 1'b0;
      puf_resp = '0;
      rd_ready = 1'b0;

      $display("[TB] reset state");
      tick();
      checkOutput("reset_outputs",
                  {216'd0, grant, busy, puf_start, rd_valid, rd_last, rd_err, rd_data}, '0);
      rst = 1'b0;
      tick();

      $display("[TB] stray done in idle");
      puf_done = 1'b1;
      puf_resp = {8{$urandom}};
      tick();
      puf_done = 1'b0;
      checkOutput("stray_idle", {254'd0, busy, puf_start}, '0);

      $display("[TB] single request, byte pattern");
      for (int i = 0; i < RESP_W / 8; i++) begin
         pat[i*8 +: 8] = 8'(i + 1);
      end
      applyStimulus(4'b0001, 300, pat, 0, -1);

      $display("[TB] round robin after reset");
      applyReset();
      applyStimulus(4'b1111, 5, {8{$urandom}}, 0, -1);
      applyStimulus(4'b1111, 9, {8{$urandom}}, 0, -1);
      applyStimulus(4'b1111, 0, {8{$urandom}}, 0, -1);

      $display("[TB] backpressure");
      applyStimulus(4'b1010, 12, {8{$urandom}}, 1, -1);

      $display("[TB] timeout");
      applyStimulus(4'b0100, -1, '0, 0, -1);

      $display("[TB] done coincident with watchdog expiry");
      applyStimulus(4'b0011, TMO, {8{$urandom}}, 2, -1);

      $display("[TB] reset during stream beat 3");
      applyStimulus(4'b1000, 7, {8{$urandom}}, 0, 3);
      applyStimulus(4'b0100, 4, {8{$urandom}}, 0, -1);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 12; t++) begin
         int d;
         d = (($urandom % 5) == 0) ? -1 : int'($urandom_range(0, 40));
         if (t == 6) d = TMO;
         applyStimulus(NREQ'($urandom_range(1, 15)), d, {8{$urandom}}, 2, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
